// File: rtl/shot_controller_if.sv
// shot_controller_if
//   Bundles the signals between the mouse/game side and the shot controller.
//   The master modport drives the mouse and projectile inputs and receives
//   the fire/kill commands and the status. The slave modport is the
//   controller's own view of the same signals.
//   Mouse and frame inputs : left_click, right_click, x_pos_in, y_pos_in, v_sync_in
//   Projectile feedback    : hit, proj_done
//   Commands to projectile : fire, proj_kill, target_x, target_y
//   Status                 : ammo_count, busy, reloading, score
interface shot_controller_if;
  logic        left_click;
  logic        right_click;
  logic [11:0] x_pos_in;
  logic [11:0] y_pos_in;
  logic        v_sync_in;
  logic        hit;
  logic        proj_done;
  logic        fire;
  logic        proj_kill;
  logic [11:0] target_x;
  logic [11:0] target_y;
  logic [3:0]  ammo_count;
  logic        busy;
  logic        reloading;
  logic [7:0]  score;

  modport master (
    output left_click, right_click, x_pos_in, y_pos_in, v_sync_in, hit, proj_done,
    input  fire, proj_kill, target_x, target_y, ammo_count, busy, reloading, score
  );

  modport slave (
    input  left_click, right_click, x_pos_in, y_pos_in, v_sync_in, hit, proj_done,
    output fire, proj_kill, target_x, target_y, ammo_count, busy, reloading, score
  );
endinterface

// File: rtl/shot_controller.sv
// shot_controller
//   Turns raw mouse clicks into single, rate-limited fire commands, latches
//   the target coordinates, and tracks the magazine, projectile flight
//   timeout, cooldown, reload and hit score. All timers advance once per
//   frame on the rising edge of v_sync_in.
//   clk : pixel clock, rising edge active
//   rst : asynchronous, active-low reset
//   bus : shot_controller_if slave view (mouse/frame inputs, projectile
//         feedback, fire/kill commands, target, ammo, busy, reloading, score)
module shot_controller #(
  parameter int MAG_SIZE          = 6,
  parameter int COOLDOWN_FRAMES   = 15,
  parameter int RELOAD_FRAMES     = 120,
  parameter int MAX_FLIGHT_FRAMES = 90,
  parameter int X_MAX             = 799,
  parameter int Y_MAX             = 599
) (
  input  logic                     clk,
  input  logic                     rst,
  shot_controller_if.slave         bus
);

  localparam logic [3:0]  MAG_FULL    = 4'(MAG_SIZE);
  localparam logic [7:0]  COOL_LAST   = 8'(COOLDOWN_FRAMES - 1);
  localparam logic [7:0]  RELOAD_LAST = 8'(RELOAD_FRAMES - 1);
  localparam logic [7:0]  FLIGHT_LAST = 8'(MAX_FLIGHT_FRAMES - 1);
  localparam logic [11:0] X_LIM       = 12'(X_MAX);
  localparam logic [11:0] Y_LIM       = 12'(Y_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FIRE,
    S_FLIGHT,
    S_COOLDOWN,
    S_RELOAD
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  timer_q, timer_d;
  logic [3:0]  ammo_q, ammo_d;
  logic [7:0]  score_q, score_d;
  logic [11:0] tx_q, tx_d;
  logic [11:0] ty_q, ty_d;
  logic        fire_q, fire_d;
  logic        kill_q, kill_d;

  // Previous-cycle samples for edge detection.
  logic        click_prev_q;
  logic        rclick_prev_q;
  logic        vsync_prev_q;

  logic        click_rise;
  logic        rclick_rise;
  logic        frame_tick;
  logic        in_bounds;

  assign click_rise  = bus.left_click  & ~click_prev_q;
  assign rclick_rise = bus.right_click & ~rclick_prev_q;
  assign frame_tick  = bus.v_sync_in   & ~vsync_prev_q;
  assign in_bounds   = (bus.x_pos_in <= X_LIM) && (bus.y_pos_in <= Y_LIM);

  always_comb begin
    state_d = state_q;
    ammo_d  = ammo_q;
    score_d = score_q;
    tx_d    = tx_q;
    ty_d    = ty_q;
    kill_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Left click has priority over a simultaneous right click.
        if (click_rise && (ammo_q != 4'd0) && in_bounds) begin
          tx_d    = bus.x_pos_in;
          ty_d    = bus.y_pos_in;
          state_d = S_FIRE;
        end else if (click_rise && (ammo_q == 4'd0)) begin
          state_d = S_RELOAD;
        end else if (rclick_rise && (ammo_q < MAG_FULL)) begin
          state_d = S_RELOAD;
        end
      end

      S_FIRE: begin
        ammo_d  = ammo_q - 4'd1;
        state_d = S_FLIGHT;
      end

      S_FLIGHT: begin
        // A hit or proj_done on the timeout tick resolves the shot normally.
        if (bus.hit) begin
          if (score_q != 8'hFF) begin
            score_d = score_q + 8'd1;
          end
          state_d = S_COOLDOWN;
        end else if (bus.proj_done) begin
          state_d = S_COOLDOWN;
        end else if (frame_tick && (timer_q == FLIGHT_LAST)) begin
          kill_d  = 1'b1;
          state_d = S_COOLDOWN;
        end
      end

      S_COOLDOWN: begin
        if (frame_tick && (timer_q == COOL_LAST)) begin
          state_d = (ammo_q == 4'd0) ? S_RELOAD : S_IDLE;
        end
      end

      S_RELOAD: begin
        if (frame_tick && (timer_q == RELOAD_LAST)) begin
          ammo_d  = MAG_FULL;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // fire is registered: it is high for exactly the cycle spent in FIRE.
    fire_d = (state_d == S_FIRE);

    // Timer restarts at every state change so each timed state counts
    // frames from its own entry.
    if (state_d != state_q) begin
      timer_d = 8'd0;
    end else begin
      timer_d = timer_q + {7'd0, frame_tick};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      timer_q       <= 8'd0;
      ammo_q        <= MAG_FULL;
      score_q       <= 8'd0;
      tx_q          <= 12'd0;
      ty_q          <= 12'd0;
      fire_q        <= 1'b0;
      kill_q        <= 1'b0;
      // Buttons held through reset must not look like a fresh press.
      click_prev_q  <= 1'b1;
      rclick_prev_q <= 1'b1;
      vsync_prev_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      ammo_q        <= ammo_d;
      score_q       <= score_d;
      tx_q          <= tx_d;
      ty_q          <= ty_d;
      fire_q        <= fire_d;
      kill_q        <= kill_d;
      click_prev_q  <= bus.left_click;
      rclick_prev_q <= bus.right_click;
      vsync_prev_q  <= bus.v_sync_in;
    end
  end

  assign bus.fire       = fire_q;
  assign bus.proj_kill  = kill_q;
  assign bus.target_x   = tx_q;
  assign bus.target_y   = ty_q;
  assign bus.ammo_count = ammo_q;
  assign bus.score      = score_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.reloading  = (state_q == S_RELOAD);

endmodule

// File: doc/shot_controller.md
Name: shot_controller

Overview:
Sequences the projectile datapath for the shooting game. It turns raw mouse clicks into single, rate-limited fire commands and latches the target coordinates. It tracks the magazine, flight timeout, cooldown and reload, and counts hits. It sits between the mouse interface and the projectile/render block, and advances its timers once per frame on the rising edge of v_sync.

Parameters:
MAG_SIZE, 6, shots per magazine (1..15)
COOLDOWN_FRAMES, 15, frames between the end of one shot and the next allowed shot (1..255)
RELOAD_FRAMES, 120, frames needed to refill the magazine (1..255)
MAX_FLIGHT_FRAMES, 90, frames before an unresolved projectile is killed (1..255)
X_MAX, 799, largest valid target x
Y_MAX, 599, largest valid target y

Ports:
clk  in  1  posedge clock, the pixel clock domain
rst  in  1  asynchronous, active-low reset
left_click  in  1  mouse left button level
right_click  in  1  mouse right button level, requests a manual reload
x_pos_in  in  12  mouse x
y_pos_in  in  12  mouse y
v_sync_in  in  1  vertical sync; its rising edge is the frame tick
hit  in  1  projectile hit a target (1-cycle pulse)
proj_done  in  1  projectile left the screen (1-cycle pulse)
fire  out  1  1-cycle pulse that starts a projectile
proj_kill  out  1  1-cycle pulse that aborts the projectile on timeout
target_x  out  12  latched target x, valid from fire onward
target_y  out  12  latched target y
ammo_count  out  4  rounds remaining
busy  out  1  high in every state except IDLE
reloading  out  1  high in RELOAD
score  out  8  hit counter, saturates at 255

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, ammo_count=MAG_SIZE.
  - fire, proj_kill, busy, reloading, target_x, target_y, score and timer are 0.
  - click_d and rclick_d are set to 1, so a button held through reset does not fire.
  - vsync_d is set to 0.
  - Reset asserted mid-flight aborts with no kill pulse.
- Edge detection:
  - click_rise = left_click & ~click_d; rclick_rise is formed the same way.
  - frame_tick = v_sync_in & ~vsync_d.
  - All detect registers update every cycle.
- Timer: 8-bit. Cleared on every state entry and incremented on frame_tick. A state exits "after N frames" on the frame_tick at which timer==N-1.
- IDLE:
  - click_rise, ammo_count>0, x_pos_in<=X_MAX and y_pos_in<=Y_MAX: latch target_x/y from the same-cycle inputs, go to FIRE.
  - click_rise with ammo_count==0: go to RELOAD.
  - click_rise with an out-of-bounds target: ignored.
  - rclick_rise with ammo_count<MAG_SIZE: go to RELOAD. If click_rise and rclick_rise arrive together, the left click wins.
- FIRE (exactly 1 cycle):
  - fire=1 during this cycle, i.e. the cycle after the detecting edge (latency 1).
  - ammo_count decrements by 1.
  - Next state is FLIGHT.
- FLIGHT:
  - hit: score+1 (saturating), go to COOLDOWN.
  - proj_done without hit: go to COOLDOWN.
  - hit and proj_done in the same cycle: one increment.
  - Timeout after MAX_FLIGHT_FRAMES with no hit/proj_done: proj_kill=1 for the transition cycle, go to COOLDOWN.
  - hit coincident with timeout: hit wins, no proj_kill.
- COOLDOWN:
  - After COOLDOWN_FRAMES, go to RELOAD if ammo_count==0, else IDLE.
  - hit/proj_done are ignored here.
- RELOAD:
  - After RELOAD_FRAMES, ammo_count=MAG_SIZE, go to IDLE.
  - reloading=1 throughout.
- Clicks outside IDLE are discarded; there is no queueing. A held button never re-fires; a new rising edge is required.
- target_x/y hold their value until the next FIRE entry.
- busy and reloading are decoded from the registered state.
- fire and proj_kill are registered outputs.

Test Plan:
- Reset held with left_click=1, then released, button stays high -> fire never asserts; ammo_count=6.
- Click at (300,200) in IDLE -> fire high for 1 cycle, one cycle after the detecting edge; target=(300,200); ammo_count=5; busy=1.
- After fire, pulse hit at frame 10 -> score=1, no proj_kill. A second click during cooldown is ignored. IDLE is re-entered 15 frame ticks later.
- No hit/proj_done after fire -> proj_kill pulses on the 90th frame tick, then COOLDOWN. Also drive hit on that same cycle -> score+1 and no proj_kill.
- Fire 6 shots, each resolved by proj_done -> after the 6th cooldown, RELOAD with reloading=1. After 120 frames, ammo_count=6 and IDLE.
- Click at (800,100) -> ignored, ammo unchanged. right_click with ammo=4 -> RELOAD. Simultaneous left/right rising edges with ammo=4 -> fire wins.
